io_out_port: RTL and testbench

IO_OUT_PORT -- requirements
Module: io_out_port

---
 rtl/io_out_port_pkg.sv | 26 ++
 rtl/io_sync_fifo.sv | 83 ++++++++
 rtl/io_out_port.sv | 104 ++++++++++
 tb/tb_io_out_port.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/io_out_port_pkg.sv
// io_out_port_pkg
// Shared definitions for the CPU-to-stream output port: default parameter
// values, the drop counter width, a channel-width helper and a reference
// queue-entry layout {ch, data} at the default widths.
package io_out_port_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_NUM_CH = 4;
  localparam int DROP_W     = 16;

  // Channel index width: at least one bit even for a single channel.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_CH_W = ch_width(DEF_NUM_CH);

  // Queue entry layout; the top packs entries the same way ({ch, data})
  // at its own parameterised widths.
  typedef struct packed {
    logic [DEF_CH_W-1:0]   ch;
    logic [DEF_DATA_W-1:0] data;
  } io_entry_t;

endpackage

// File: rtl/io_sync_fifo.sv
// io_sync_fifo
// Single-clock FIFO with a registered head. The head register only changes
// on a pop or on a push into an empty queue, so consumers see stable data.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   push, push_data        write request and entry (dropped if full w/o pop)
//   pop                    remove head (ignored when empty)
//   full, empty            occupancy flags (combinational from count)
//   level                  entries held, 0..DEPTH
//   head_valid, head_data  registered head of queue
module io_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic [LW-1:0]    count_nxt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == LW'(DEPTH));
  assign level   = count;
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + LW'(1);
      2'b01:   count_nxt = count - LW'(1);
      default: count_nxt = count;
    endcase
  end

  // Storage array carries no reset; only entries below count are observed.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
      head_data  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count      <= count_nxt;
      head_valid <= (count_nxt != '0);
      if (do_pop) begin
        // Next entry is already in memory when more than one is held;
        // otherwise a same-cycle push becomes the new head directly.
        if (count > LW'(1))
          head_data <= mem[rd_ptr + AW'(1)];
        else if (do_push)
          head_data <= push_data;
      end else if (do_push && empty) begin
        head_data <= push_data;
      end
    end
  end

endmodule

// File: rtl/io_out_port.sv
// io_out_port
// CPU output port: CPU write strobes are filtered by channel, queued as
// {ch, data} in a FIFO and presented on a valid/ready stream. Writes that
// find the queue full (and no simultaneous pop) are dropped and counted.
// Build option: define IO_OUT_PORT_EDGE_DET_EN to push once per rising edge
// of io_write; otherwise every cycle with io_write high is a write.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   io_write, io_ch, io_data   CPU write strobe, target channel, data
//   out_valid, out_ready       stream handshake
//   out_data, out_ch           head entry
//   level                      entries held
//   overflow                   sticky: a write was dropped
//   drop_cnt                   dropped writes, saturating
module io_out_port
  import io_out_port_pkg::*;
#(
  parameter  int                DATA_W  = DEF_DATA_W,
  parameter  int                DEPTH   = DEF_DEPTH,
  parameter  int                NUM_CH  = DEF_NUM_CH,
  parameter  logic [NUM_CH-1:0] CH_MASK = '1,
  localparam int                CH_W    = ch_width(NUM_CH),
  localparam int                LVL_W   = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              io_write,
  input  logic [CH_W-1:0]   io_ch,
  input  logic [DATA_W-1:0] io_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic [LVL_W-1:0]  level,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int CH_N  = 1 << CH_W;
  localparam int ENT_W = CH_W + DATA_W;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == '1) ? v : v + DROP_W'(1);
  endfunction

  // Mask widened to every encodable channel; codes >= NUM_CH read as 0.
  logic [CH_N-1:0]  mask_ext;
  logic             wr_event;
  logic             accept;
  logic             pop;
  logic             drop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [ENT_W-1:0] head;

  assign mask_ext = CH_N'(CH_MASK);

`ifdef IO_OUT_PORT_EDGE_DET_EN
  logic io_write_p1;

  always_ff @(posedge clk) begin
    if (rst) io_write_p1 <= 1'b0;
    else     io_write_p1 <= io_write;
  end

  assign wr_event = io_write && !io_write_p1;
`else
  assign wr_event = io_write;
`endif

  assign accept = wr_event && mask_ext[io_ch];
  assign pop    = out_ready && !fifo_empty;
  assign drop   = accept && fifo_full && !pop;

  io_sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (accept),
    .push_data  ({io_ch, io_data}),
    .pop        (pop),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .level      (level),
    .head_valid (out_valid),
    .head_data  (head)
  );

  assign out_ch   = head[ENT_W-1:DATA_W];
  assign out_data = head[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      drop_cnt <= sat_inc(drop_cnt);
    end
  end

endmodule

// File: tb/tb_io_out_port.sv
module tb_io_out_port;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 8;
  localparam int NUM_CH = 4;
`ifdef IO_OUT_PORT_EDGE_DET_EN
  localparam int HOLD3  = 1;
`else
  localparam int HOLD3  = 3;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              io_write = 1'b0;
  logic [1:0]        io_ch = '0;
  logic [DATA_W-1:0] io_data = '0;
  logic              out_ready = 1'b0;

  logic              out_valid,  m_out_valid;
  logic [DATA_W-1:0] out_data,   m_out_data;
  logic [1:0]        out_ch,     m_out_ch;
  logic [3:0]        level,      m_level;
  logic              overflow,   m_overflow;
  logic [15:0]       drop_cnt,   m_drop_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  io_out_port #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_CH(NUM_CH)) dut (
    .clk(clk), .rst(rst), .io_write(io_write), .io_ch(io_ch), .io_data(io_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .level(level), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  io_out_port #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_CH(NUM_CH),
                .CH_MASK(4'b0101)) dut_m (
    .clk(clk), .rst(rst), .io_write(io_write), .io_ch(io_ch), .io_data(io_data),
    .out_valid(m_out_valid), .out_ready(out_ready), .out_data(m_out_data),
    .out_ch(m_out_ch), .level(m_level), .overflow(m_overflow), .drop_cnt(m_drop_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle write strobe followed by an idle cycle.
  task automatic pulse(input logic [1:0] ch, input logic [63:0] d);
    io_write = 1'b1; io_ch = ch; io_data = d;
    tick();
    io_write = 1'b0;
    tick();
  endtask

  // Pop one entry of main DUT, checking head first.
  task automatic pop_chk(input string tag, input logic [63:0] d, input logic [1:0] ch);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_data"}, out_data, d);
    chk({tag, "_ch"}, 64'(out_ch), 64'(ch));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    // Reset, with a write held during reset that must be ignored.
    rst = 1'b1; io_write = 1'b1; io_ch = 2'd0; io_data = 64'd5;
    tick();
    tick();
    rst = 1'b0; io_write = 1'b0;
    tick();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_ch", 64'(out_ch), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);

    // Three-cycle strobe of 42 on channel 0.
    io_write = 1'b1; io_ch = 2'd0; io_data = 64'd42;
    tick();
    chk("w3_lat_valid", 64'(out_valid), 64'd1);
    chk("w3_lat_data", out_data, 64'd42);
    tick();
    tick();
    io_write = 1'b0;
    chk("w3_level", 64'(level), 64'(HOLD3));
    tick();
    for (int i = 0; i < HOLD3; i++) pop_chk("w3_pop", 64'd42, 2'd0);
    chk("w3_empty_level", 64'(level), 64'd0);
    chk("w3_empty_valid", 64'(out_valid), 64'd0);

    // Ready while empty does nothing.
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("idle_ready_level", 64'(level), 64'd0);

    // Ten writes into an 8-deep queue with no consumer.
    for (int i = 1; i <= 10; i++) pulse(2'd0, 64'(i));
    chk("ovf_level", 64'(level), 64'd8);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_drop", 64'(drop_cnt), 64'd2);
    for (int i = 1; i <= 8; i++) pop_chk("ovf_pop", 64'(i), 2'd0);
    chk("ovf_drained", 64'(level), 64'd0);
    chk("ovf_sticky", 64'(overflow), 64'd1);

    // Fill again, then write 99 while popping in the same cycle.
    for (int i = 11; i <= 18; i++) pulse(2'd2, 64'(i));
    chk("fp_full", 64'(level), 64'd8);
    io_write = 1'b1; io_ch = 2'd2; io_data = 64'd99; out_ready = 1'b1;
    tick();
    io_write = 1'b0; out_ready = 1'b0;
    chk("fp_level", 64'(level), 64'd8);
    chk("fp_drop", 64'(drop_cnt), 64'd2);
    chk("fp_head", out_data, 64'd12);
    tick();
    for (int i = 12; i <= 18; i++) pop_chk("fp_pop", 64'(i), 2'd2);
    pop_chk("fp_last", 64'd99, 2'd2);

    // Mid-level simultaneous push and pop keeps level.
    pulse(2'd1, 64'd31);
    pulse(2'd1, 64'd32);
    io_write = 1'b1; io_ch = 2'd3; io_data = 64'd33; out_ready = 1'b1;
    tick();
    io_write = 1'b0; out_ready = 1'b0;
    chk("pp_level", 64'(level), 64'd2);
    chk("pp_head", out_data, 64'd32);
    tick();
    pop_chk("pp_pop1", 64'd32, 2'd1);
    pop_chk("pp_pop2", 64'd33, 2'd3);

    // Masked instance: reset it clean, then writes to channels 1 and 3.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    pulse(2'd1, 64'd5);
    pulse(2'd3, 64'd6);
    chk("mask_13_level", 64'(m_level), 64'd0);
    chk("mask_13_valid", 64'(m_out_valid), 64'd0);
    chk("nomask_13_level", 64'(level), 64'd2);
    pulse(2'd2, 64'd7);
    chk("mask_2_level", 64'(m_level), 64'd1);
    chk("mask_2_ch", 64'(m_out_ch), 64'd2);
    chk("mask_2_data", m_out_data, 64'd7);

    // Force a drop, bring the main queue to five, then reset mid-operation.
    for (int i = 0; i < 6; i++) pulse(2'd0, 64'(100 + i));
    chk("pre_rst_ovf", 64'(overflow), 64'd1);
    chk("pre_rst_drop", 64'(drop_cnt), 64'd1);
    for (int i = 0; i < 3; i++) begin
      out_ready = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    chk("pre_rst_level", 64'(level), 64'd5);
    rst = 1'b1; io_write = 1'b1; io_ch = 2'd0; io_data = 64'd77;
    tick();
    rst = 1'b0; io_write = 1'b0;
    chk("mrst_level", 64'(level), 64'd0);
    chk("mrst_valid", 64'(out_valid), 64'd0);
    chk("mrst_ovf", 64'(overflow), 64'd0);
    chk("mrst_drop", 64'(drop_cnt), 64'd0);
    chk("mrst_m_level", 64'(m_level), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
